pc_redirect_unit: RTL and testbench

//  Fetch-side consumer of BJ_SIG: owns the program counter and turns a taken branch/jump

---
 rtl/pc_redirect_unit.sv | 125 ++++++++++++
 tb/tb_pc_redirect_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-side program counter owner.
// Converts a taken branch/jump resolved in EX into a PC redirect plus
// IF/ID and ID/EX squashes, and parks the redirect target while an
// instruction fetch is still outstanding.
// Optional feature macro: PC_MISALIGN_TRAP_EN (misaligned targets redirect
// to TRAP_VECTOR and pulse MISALIGN_TRAP); undefined by default.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        BJ_SIG,
  input  logic [31:0] TARGET_ADDR,
  input  logic        STALL,
  input  logic        IMEM_BUSYWAIT,
  output logic        IMEM_READ,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS_4,
  output logic        FLUSH_IF_ID,
  output logic        FLUSH_ID_EX,
  output logic        MISALIGN_TRAP
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pending_q;
  logic              imem_read_q;
  logic              trap_q;

  logic              take_c;
  logic              redirect_c;
  logic [XLEN-1:0]   tgt_raw_c;
  logic [XLEN-1:0]   tgt_c;
  logic              trap_d;

  // Redirect decode: which source feeds the PC and which stages get squashed
  always_comb begin
    take_c     = 1'b0;
    redirect_c = 1'b0;
    tgt_raw_c  = TARGET_ADDR;
    if (state_q == RUN) begin
      take_c     = BJ_SIG & ~STALL;
      redirect_c = take_c & ~IMEM_BUSYWAIT;
    end else if (state_q == HOLD) begin
      tgt_raw_c  = pending_q;
      redirect_c = ~IMEM_BUSYWAIT;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_c;

  // Misaligned targets divert to the trap vector and raise a one-cycle flag
  always_comb begin
    misalign_c = |tgt_raw_c[1:0];
    tgt_c      = misalign_c ? TRAP_VECTOR : tgt_raw_c;
    trap_d     = redirect_c & misalign_c;
  end
`else
  logic unused_tgt_c;
  assign unused_tgt_c = ^{TRAP_VECTOR, tgt_raw_c[1:0]};

  // Without the trap, the low two target bits are simply dropped
  always_comb begin
    tgt_c  = {tgt_raw_c[XLEN-1:2], 2'b00};
    trap_d = 1'b0;
  end
`endif

  // Control FSM plus PC, pending-target and trap-flag registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= BOOT;
      pc_q        <= RESET_VECTOR;
      pending_q   <= '0;
      imem_read_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      trap_q <= trap_d;
      case (state_q)
        BOOT: begin
          state_q     <= RUN;
          imem_read_q <= 1'b1;
        end
        RUN: begin
          if (take_c && !IMEM_BUSYWAIT) begin
            pc_q <= tgt_c;
          end else if (take_c) begin
            pending_q <= TARGET_ADDR;
            state_q   <= HOLD;
          end else if (!(STALL || IMEM_BUSYWAIT)) begin
            pc_q <= pc_q + XLEN'(4);
          end
        end
        HOLD: begin
          if (!IMEM_BUSYWAIT) begin
            pc_q    <= tgt_c;
            state_q <= RUN;
          end
        end
        default: begin
          state_q     <= BOOT;
          imem_read_q <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_READ     = imem_read_q;
  assign PC            = pc_q;
  assign PC_PLUS_4     = pc_q + XLEN'(4);
  assign FLUSH_IF_ID   = redirect_c;
  assign FLUSH_ID_EX   = take_c;
  assign MISALIGN_TRAP = trap_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: sequential fetch, idle and busy
// redirects, stall hold-off, misaligned targets, PC wrap and async reset.
module tb_pc_redirect_unit;

  logic        CLK;
  logic        RESET_N;
  logic        BJ_SIG;
  logic [31:0] TARGET_ADDR;
  logic        STALL;
  logic        IMEM_BUSYWAIT;
  logic        IMEM_READ;
  logic [31:0] PC;
  logic [31:0] PC_PLUS_4;
  logic        FLUSH_IF_ID;
  logic        FLUSH_ID_EX;
  logic        MISALIGN_TRAP;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .BJ_SIG        (BJ_SIG),
    .TARGET_ADDR   (TARGET_ADDR),
    .STALL         (STALL),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .IMEM_READ     (IMEM_READ),
    .PC            (PC),
    .PC_PLUS_4     (PC_PLUS_4),
    .FLUSH_IF_ID   (FLUSH_IF_ID),
    .FLUSH_ID_EX   (FLUSH_ID_EX),
    .MISALIGN_TRAP (MISALIGN_TRAP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_flush(input string tag, input logic ifid, input logic idex);
    chk({tag, "_if_id"}, 32'(FLUSH_IF_ID), 32'(ifid));
    chk({tag, "_id_ex"}, 32'(FLUSH_ID_EX), 32'(idex));
  endtask

  initial begin
    RESET_N       = 1'b0;
    BJ_SIG        = 1'b0;
    TARGET_ADDR   = 32'h0;
    STALL         = 1'b0;
    IMEM_BUSYWAIT = 1'b0;

    // Reset state
    edge1();
    chk("rst_pc", PC, 32'h0);
    chk("rst_read", 32'(IMEM_READ), 32'h0);
    chk("rst_trap", 32'(MISALIGN_TRAP), 32'h0);
    chk_flush("rst", 1'b0, 1'b0);
    edge1();
    RESET_N = 1'b1;
    #1;

    // 1. Boot then sequential fetch: 0, 0, 4, 8, 12
    chk("boot_pc", PC, 32'h0);
    chk("boot_read", 32'(IMEM_READ), 32'h0);
    chk("boot_pc4", PC_PLUS_4, 32'h4);
    edge1();
    chk("run0_pc", PC, 32'h0);
    chk("run0_read", 32'(IMEM_READ), 32'h1);
    edge1();
    chk("seq_pc4", PC, 32'h4);
    edge1();
    chk("seq_pc8", PC, 32'h8);
    edge1();
    chk("seq_pc12", PC, 32'hC);
    repeat (13) edge1();
    chk("seq_pc40", PC, 32'h40);

    // 2. Idle-memory redirect: both flushes, next PC = target
    BJ_SIG = 1'b1;
    TARGET_ADDR = 32'h200;
    #1;
    chk_flush("take_idle", 1'b1, 1'b1);
    edge1();
    chk("idle_pc", PC, 32'h200);
    BJ_SIG = 1'b0;
    #1;
    chk_flush("after_idle", 1'b0, 1'b0);

    // Return to 0x40 for the busy scenario
    BJ_SIG = 1'b1;
    TARGET_ADDR = 32'h40;
    edge1();
    BJ_SIG = 1'b0;
    chk("back_pc40", PC, 32'h40);

    // 3. Redirect while fetch outstanding: park target, flush ID/EX only
    IMEM_BUSYWAIT = 1'b1;
    BJ_SIG = 1'b1;
    TARGET_ADDR = 32'h300;
    #1;
    chk_flush("take_busy", 1'b0, 1'b1);
    edge1();
    chk("hold_pc", PC, 32'h40);
    BJ_SIG = 1'b1;
    TARGET_ADDR = 32'h500;
    STALL = 1'b1;
    #1;
    chk_flush("hold_ignore", 1'b0, 1'b0);
    edge1();
    chk("hold_pc_b", PC, 32'h40);
    BJ_SIG = 1'b0;
    STALL = 1'b0;
    edge1();
    chk("hold_pc_c", PC, 32'h40);
    chk("hold_read", 32'(IMEM_READ), 32'h1);
    IMEM_BUSYWAIT = 1'b0;
    #1;
    chk_flush("hold_release", 1'b1, 1'b0);
    edge1();
    chk("busy_pc", PC, 32'h300);
    edge1();
    chk("busy_next", PC, 32'h304);

    // 4. Branch held under stall: frozen until stall drops
    BJ_SIG = 1'b1;
    TARGET_ADDR = 32'h600;
    STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_flush("stall", 1'b0, 1'b0);
      edge1();
      chk("stall_pc", PC, 32'h304);
    end
    STALL = 1'b0;
    #1;
    chk_flush("stall_drop", 1'b1, 1'b1);
    edge1();
    chk("stall_redir", PC, 32'h600);

    // 5. Misaligned target 0x202
    TARGET_ADDR = 32'h202;
    edge1();
    BJ_SIG = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_pc", PC, 32'h100);
    chk("mis_trap", 32'(MISALIGN_TRAP), 32'h1);
    edge1();
    chk("mis_trap_end", 32'(MISALIGN_TRAP), 32'h0);
    chk("mis_next", PC, 32'h104);
`else
    chk("mis_pc", PC, 32'h200);
    chk("mis_trap", 32'(MISALIGN_TRAP), 32'h0);
    edge1();
    chk("mis_trap_end", 32'(MISALIGN_TRAP), 32'h0);
    chk("mis_next", PC, 32'h204);
`endif

    // PC wrap at top of address space
    BJ_SIG = 1'b1;
    TARGET_ADDR = 32'hFFFF_FFFC;
    edge1();
    BJ_SIG = 1'b0;
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pc4", PC_PLUS_4, 32'h0);
    edge1();
    chk("wrap_zero", PC, 32'h0);
    edge1();
    chk("wrap_four", PC, 32'h4);

    // 6. Async reset in HOLD drops the parked target
    IMEM_BUSYWAIT = 1'b1;
    BJ_SIG = 1'b1;
    TARGET_ADDR = 32'h700;
    edge1();
    BJ_SIG = 1'b0;
    chk("pre_rst_hold_pc", PC, 32'h4);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_rst_pc", PC, 32'h0);
    chk("async_rst_read", 32'(IMEM_READ), 32'h0);
    chk_flush("async_rst", 1'b0, 1'b0);
    IMEM_BUSYWAIT = 1'b0;
    #1;
    RESET_N = 1'b1;
    #1;
    chk_flush("post_rst_boot", 1'b0, 1'b0);
    edge1();
    chk("post_rst_run", PC, 32'h0);
    edge1();
    chk("post_rst_seq", PC, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
